int_sequencer: RTL and testbench

Interrupt priority arbiter and CPU entry sequencer for the interrupt unit. It collects level-sensitive maskable requests and one non-maskable request, selects the highest-priority eligible source, and presents its 6-bit IVT index to the CPU with a request/acknowledge handshake. It returns a one-cycle acknowledge pulse to the winning source and blocks re-arbitration while the CPU performs its interrupt entry sequence (push PC, push SR, vector fetch). It sits between the per-peripheral interrupt flag logic and the CPU control FSM, below the BOR/POR/PUC reset chain.

---
 rtl/int_sequencer.sv | 153 +++++++++++++++
 tb/tb_int_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// int_sequencer: interrupt priority arbiter and CPU entry sequencer.
// Picks the highest-priority eligible request (NMI > IRQ[NSRC-1] > ... > IRQ[0]).
// It presents the request's IVT index to the CPU with a request/acknowledge
// handshake, pulses an acknowledge back to the winning source, and then stays
// busy while the CPU runs its interrupt entry sequence.
// Optional feature macro: INTSEQ_NMI_EN enables the non-maskable request path.
// Without the macro, NMI is ignored and NMIACK is tied low.
module int_sequencer #(
  parameter int              NSRC      = 8,
  parameter int              AW        = 6,
  parameter logic [AW-1:0]   VEC_BASE  = 6'd32,
  parameter logic [AW-1:0]   NMI_VEC   = 6'd61,
  parameter int              ENTRY_CYC = 6
) (
  input  logic            MCLK,
  input  logic            RST,
  input  logic [NSRC-1:0] IRQ,
  input  logic            NMI,
  input  logic            GIE,
  input  logic            INTACK,
  output logic            INTREQ,
  output logic [AW-1:0]   IntAddr,
  output logic [NSRC-1:0] INTACKout,
  output logic            NMIACK,
  output logic            BUSY
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACK   = 2'd2,
    ENTRY = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   winIdx_q, winIdx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NSRC-1:0] irqElig;
  logic            irqAny;
  logic [IW-1:0]   arbIdx;
  logic            anyElig;
  logic [AW-1:0]   arbAddr;
  logic            winNmi;

`ifdef INTSEQ_NMI_EN
  logic nmi_q, nmi_d;
  assign winNmi = nmi_q;
`else
  logic unusedNmi;
  assign unusedNmi = NMI;
  assign winNmi    = 1'b0;
`endif

  // Combinational priority pick of the highest eligible source this cycle
  always_comb begin
    irqElig = GIE ? IRQ : '0;
    irqAny  = |irqElig;
    arbIdx  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (irqElig[i]) begin
        arbIdx = IW'(i);
      end
    end
`ifdef INTSEQ_NMI_EN
    anyElig = NMI | irqAny;
    arbAddr = NMI ? NMI_VEC : VEC_BASE + AW'(arbIdx);
`else
    anyElig = irqAny;
    arbAddr = VEC_BASE + AW'(arbIdx);
`endif
  end

  // Next-state logic: handshake with the CPU and entry-sequence countdown
  always_comb begin
    state_d  = state_q;
    winIdx_d = winIdx_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
`ifdef INTSEQ_NMI_EN
    nmi_d    = nmi_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyElig) begin
          state_d  = REQ;
          winIdx_d = arbIdx;
          addr_d   = arbAddr;
`ifdef INTSEQ_NMI_EN
          nmi_d    = NMI;
`endif
        end
      end
      REQ: begin
        if (INTACK) begin
          state_d = ACK;
        end else if (anyElig) begin
          winIdx_d = arbIdx;
          addr_d   = arbAddr;
`ifdef INTSEQ_NMI_EN
          nmi_d    = NMI;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        cnt_d   = CW'(ENTRY_CYC - 1);
        state_d = ENTRY;
      end
      ENTRY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, winner and counter registers; reset aborts any sequence at once
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      winIdx_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
`ifdef INTSEQ_NMI_EN
      nmi_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      winIdx_q <= winIdx_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
`ifdef INTSEQ_NMI_EN
      nmi_q    <= nmi_d;
`endif
    end
  end

  assign INTREQ    = (state_q == REQ);
  assign BUSY      = (state_q == ACK) || (state_q == ENTRY);
  assign IntAddr   = addr_q;
  assign INTACKout = ((state_q == ACK) && !winNmi) ? (NSRC'(1'b1) << winIdx_q) : '0;
  assign NMIACK    = (state_q == ACK) && winNmi;

endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: directed bench for int_sequencer.
// A cycle-level behavioural model predicts every output, and a per-cycle
// compare process checks it. Hand-computed literal checks pin the model.
// The bench follows the INTSEQ_NMI_EN macro in the same way as the design.
module tb_int_sequencer;

  localparam int NSRC      = 8;
  localparam int AW        = 6;
  localparam int ENTRY_CYC = 6;
`ifdef INTSEQ_NMI_EN
  localparam bit NMI_EN = 1'b1;
`else
  localparam bit NMI_EN = 1'b0;
`endif

  logic            MCLK = 1'b0;
  logic            RST = 1'b0;
  logic [NSRC-1:0] IRQ = '0;
  logic            NMI = 1'b0;
  logic            GIE = 1'b0;
  logic            INTACK = 1'b0;
  logic            INTREQ;
  logic [AW-1:0]   IntAddr;
  logic [NSRC-1:0] INTACKout;
  logic            NMIACK;
  logic            BUSY;

  int checks = 0;
  int fails  = 0;

  // Model state: pending request, busy cycles left, and the last presented winner
  bit       mPend = 0;
  int       mBusy = 0;
  bit       mAck = 0;
  bit       mNmi = 0;
  int       mIdx = 0;
  logic [AW-1:0] mAddr = '0;

  int_sequencer #(
    .NSRC(NSRC), .AW(AW), .VEC_BASE(6'd32), .NMI_VEC(6'd61), .ENTRY_CYC(ENTRY_CYC)
  ) dut (
    .MCLK(MCLK), .RST(RST), .IRQ(IRQ), .NMI(NMI), .GIE(GIE), .INTACK(INTACK),
    .INTREQ(INTREQ), .IntAddr(IntAddr), .INTACKout(INTACKout), .NMIACK(NMIACK), .BUSY(BUSY)
  );

  always #5 MCLK = ~MCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] irq, input logic nmi, input logic gie, input logic ack);
    IRQ    = irq;
    NMI    = nmi;
    GIE    = gie;
    INTACK = ack;
    @(posedge MCLK);
    @(negedge MCLK);
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 20; n++) begin
      if (!BUSY && mBusy == 0) break;
      applyStimulus('0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("idleReached", {31'd0, BUSY}, 32'd0);
  endtask

  // Behavioural model advancing one clock at a time from the sampled inputs
  always @(posedge MCLK or posedge RST) begin
    if (RST) begin
      mPend = 0; mBusy = 0; mAck = 0; mNmi = 0; mIdx = 0; mAddr = '0;
    end else begin
      mAck = 0;
      if (mBusy > 0) begin
        mBusy--;
      end else if (mPend && INTACK) begin
        mBusy = ENTRY_CYC + 1;
        mAck  = 1;
        mPend = 0;
      end else begin
        bit found;
        found = 0;
        if (NMI_EN && NMI) begin
          found = 1; mNmi = 1; mAddr = 6'd61;
        end else if (GIE) begin
          for (int i = NSRC - 1; i >= 0; i--) begin
            if (IRQ[i] && !found) begin
              found = 1; mNmi = 0; mIdx = i; mAddr = AW'(32 + i);
            end
          end
        end
        mPend = found;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge MCLK) begin
    if (!RST) begin
      checkOutput("INTREQ", {31'd0, INTREQ}, {31'd0, mPend});
      checkOutput("BUSY", {31'd0, BUSY}, {31'd0, (mBusy > 0)});
      checkOutput("IntAddr", {26'd0, IntAddr}, {26'd0, mAddr});
      checkOutput("INTACKout", {24'd0, INTACKout},
                  {24'd0, ((mAck && !mNmi) ? (8'(1) << mIdx) : 8'h00)});
      checkOutput("NMIACK", {31'd0, NMIACK}, {31'd0, (mAck && mNmi)});
    end
  end

  // Global time limit so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Directed scenario sequence with hand-computed expectations
  initial begin
    int busyCount;
    int gap;
    #1 RST = 1'b1;
    repeat (2) @(negedge MCLK);
    checkOutput("rstINTREQ", {31'd0, INTREQ}, 32'd0);
    checkOutput("rstIntAddr", {26'd0, IntAddr}, 32'd0);
    checkOutput("rstINTACKout", {24'd0, INTACKout}, 32'd0);
    checkOutput("rstBUSY", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    checkOutput("idleNoReq", {31'd0, INTREQ}, 32'd0);

    // Single source IRQ[3] with a timed entry sequence
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b0);
    checkOutput("irq3Req", {31'd0, INTREQ}, 32'd1);
    checkOutput("irq3Addr", {26'd0, IntAddr}, 32'd35);
    applyStimulus(8'h08, 1'b0, 1'b1, 1'b1);
    checkOutput("irq3Ack", {24'd0, INTACKout}, 32'h08);
    checkOutput("irq3AckReqLow", {31'd0, INTREQ}, 32'd0);
    busyCount = BUSY ? 1 : 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus('0, 1'b0, 1'b1, 1'(n % 2));
      if (!BUSY) break;
      busyCount++;
      checkOutput("entryReqLow", {31'd0, INTREQ}, 32'd0);
      checkOutput("entryNoAck", {24'd0, INTACKout}, 32'd0);
    end
    checkOutput("busyLength", busyCount, ENTRY_CYC + 1);
    applyStimulus('0, 1'b0, 1'b1, 1'b1);
    checkOutput("idleAckIgnored", {31'd0, INTREQ | BUSY}, 32'd0);

    // Reset asserted in the middle of the entry sequence
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b0);
    checkOutput("irq0Addr", {26'd0, IntAddr}, 32'd32);
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b1);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    checkOutput("midEntryBusy", {31'd0, BUSY}, 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("abortOutputs", {IntAddr, INTACKout, INTREQ, NMIACK, BUSY}, 32'd0);
    @(negedge MCLK);
    RST = 1'b0;
    for (int n = 0; n < 3; n++) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      checkOutput("postRstIdle", {31'd0, INTREQ}, 32'd0);
    end

    // Priority and preemption while requesting
    applyStimulus(8'h02, 1'b0, 1'b1, 1'b0);
    checkOutput("irq1Addr", {26'd0, IntAddr}, 32'd33);
    applyStimulus(8'h42, 1'b0, 1'b1, 1'b0);
    checkOutput("irq6Preempt", {26'd0, IntAddr}, 32'd38);
    applyStimulus(8'h42, 1'b1, 1'b1, 1'b0);
    checkOutput("nmiPreempt", {26'd0, IntAddr}, NMI_EN ? 32'd61 : 32'd38);
    applyStimulus(8'h42, 1'b1, 1'b1, 1'b1);
    checkOutput("nmiAckPulse", {31'd0, NMIACK}, NMI_EN ? 32'd1 : 32'd0);
    checkOutput("nmiAckIrqAck", {24'd0, INTACKout}, NMI_EN ? 32'h00 : 32'h40);
    waitIdle();

    // Withdrawal by clearing GIE, then NMI alone with GIE low
    applyStimulus(8'h04, 1'b0, 1'b1, 1'b0);
    checkOutput("irq2Addr", {26'd0, IntAddr}, 32'd34);
    applyStimulus(8'h04, 1'b0, 1'b0, 1'b0);
    checkOutput("gieDropReq", {31'd0, INTREQ}, 32'd0);
    checkOutput("gieDropNoAck", {24'd0, INTACKout}, 32'd0);
    checkOutput("gieDropHoldAddr", {26'd0, IntAddr}, 32'd34);
    applyStimulus(8'h04, 1'b1, 1'b0, 1'b0);
    checkOutput("nmiNoGieReq", {31'd0, INTREQ}, NMI_EN ? 32'd1 : 32'd0);
    checkOutput("nmiNoGieAddr", {26'd0, IntAddr}, NMI_EN ? 32'd61 : 32'd34);
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    checkOutput("nmiDropReq", {31'd0, INTREQ}, 32'd0);

    // Request drops in the same cycle that INTACK is accepted
    applyStimulus(8'h10, 1'b0, 1'b1, 1'b0);
    checkOutput("irq4Addr", {26'd0, IntAddr}, 32'd36);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("dropAckPulse", {24'd0, INTACKout}, 32'h10);
    for (int n = 0; n < ENTRY_CYC + 3; n++) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b1);
    end
    checkOutput("ackHeldIdle", {31'd0, INTREQ | BUSY}, 32'd0);
    waitIdle();

    // Back-to-back service with IRQ[5] held high
    applyStimulus(8'h20, 1'b0, 1'b1, 1'b0);
    checkOutput("irq5Addr", {26'd0, IntAddr}, 32'd37);
    applyStimulus(8'h20, 1'b0, 1'b1, 1'b1);
    checkOutput("irq5Ack", {24'd0, INTACKout}, 32'h20);
    gap = 0;
    for (int n = 1; n <= 30; n++) begin
      applyStimulus(8'h20, 1'b0, 1'b1, 1'b0);
      if (INTREQ) begin
        gap = n;
        break;
      end
    end
    checkOutput("backToBackGap", gap, ENTRY_CYC + 2);
    applyStimulus(8'h20, 1'b0, 1'b1, 1'b1);
    checkOutput("irq5Ack2", {24'd0, INTACKout}, 32'h20);
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
